// File: rtl/fifo_stream_reader.sv
// FIFO read-side engine: pops words and presents them on a valid/ready stream.
// Optional packet m_last generation is enabled with FIFO_READER_LAST_EN.
module fifo_stream_reader #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_read,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] buf_q [2];
  logic             capture;
  logic             xfer;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf_q[rd_ptr_q];
  assign xfer    = m_valid & m_ready;
  assign capture = (state_q == WAIT);

  // Gated by reset so the strobe stays low while reset is held
  assign fifo_read = reset_n && (state_q == IDLE) &&
                     !fifo_empty && (occ_q < 2'd2);

  always_comb begin
    state_d  = state_q;
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    unique case (state_q)
      IDLE: if (fifo_read) state_d = WAIT;
      WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (capture) wr_ptr_d = ~wr_ptr_q;
    if (xfer) rd_ptr_d = ~rd_ptr_q;
    unique case ({capture, xfer})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      occ_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (capture) buf_q[wr_ptr_q] <= fifo_data_out;
    end
  end

`ifdef FIFO_READER_LAST_EN
  localparam int CW = $clog2(PKT_LEN) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_end;

  assign cnt_end = (cnt_q == CW'(PKT_LEN - 1));
  assign m_last  = m_valid && cnt_end;

  always_comb begin
    cnt_d = cnt_q;
    if (xfer) cnt_d = cnt_end ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, in-order scoreboard,
// stream-rule monitor and directed/random scenarios.
module tb_fifo_stream_reader;

  localparam int W   = 8;
  localparam int PKT = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         fifo_empty;
  logic [W-1:0] fifo_data_out;
  logic         fifo_read;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic         m_last;

  logic         tst_mode = 1'b0;
  logic         tst_empty = 1'b1;
  logic [W-1:0] tst_data = '0;
  logic         mdl_empty;
  logic [W-1:0] mdl_data;

  logic [W-1:0] fq[$];
  logic [W-1:0] sb[$];

  int checks = 0;
  int errors = 0;
  int reads = 0;
  int delivered = 0;
  int pushed = 0;
  logic [31:0] last_mask = '0;

  logic         rd_s = 1'b0;
  logic         prev_rd = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  assign fifo_empty    = tst_mode ? tst_empty : mdl_empty;
  assign fifo_data_out = tst_mode ? tst_data : mdl_data;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(W), .PKT_LEN(PKT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_read(fifo_read),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last)
  );

  // Upstream FIFO: registered read data, empty flag one cycle stale
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdl_empty <= 1'b1;
      mdl_data  <= '0;
    end else begin
      mdl_empty <= (fq.size() == 0);
      if (rd_s && fq.size() > 0) mdl_data <= fq.pop_front();
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      rd_s       = 1'b0;
      prev_rd    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (fifo_read && prev_rd) begin
        errors++;
        $display("FAIL consec_read: fifo_read=1 two cycles running, required gap");
      end
      if (fifo_read && fq.size() == 0) begin
        errors++;
        $display("FAIL read_on_empty: read issued with FIFO holding 0 words");
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h, required 1/%h",
                   m_valid, m_data, prev_data);
        end
      end
      checks++;
      if (reads + int'(fifo_read) - delivered > 2) begin
        errors++;
        $display("FAIL outstanding: %0d words in reader, required <=2",
                 reads + int'(fifo_read) - delivered);
      end
      checks++;
`ifdef FIFO_READER_LAST_EN
      if (m_last !== (m_valid && (delivered % PKT) == PKT - 1)) begin
        errors++;
        $display("FAIL m_last: got %b at word %0d, required %b", m_last,
                 delivered, m_valid && (delivered % PKT) == PKT - 1);
      end
`else
      if (m_last !== 1'b0) begin
        errors++;
        $display("FAIL m_last_tied: got %b, required 0", m_last);
      end
`endif
      if (m_valid && m_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got %h, required no transfer", m_data);
        end else begin
          logic [W-1:0] exp;
          exp = sb.pop_front();
          if (m_data !== exp) begin
            errors++;
            $display("FAIL data_order: got %h, required %h", m_data, exp);
          end
        end
        if (m_last && delivered < 32) last_mask[delivered] = 1'b1;
        delivered++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_rd    = fifo_read;
      rd_s       = fifo_read;
      reads      = reads + int'(fifo_read);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    sb.push_back(w);
    pushed++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fq.delete();
    sb.delete();
    tick();
    tick();
    reads     = 0;
    delivered = 0;
    pushed    = 0;
    last_mask = '0;
    reset_n   = 1'b1;
    tick();
  endtask

  task automatic wait_delivered(input int n, input string tag);
    int k;
    k = 0;
    while (delivered < n && k < 200) begin
      tick();
      k++;
    end
    checks++;
    if (delivered != n) begin
      errors++;
      $display("FAIL %s_timeout: delivered %0d, required %0d", tag, delivered, n);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    tst_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tst_empty = 1'($urandom_range(0, 1));
      tst_data  = W'($urandom);
      m_ready   = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({fifo_read, m_valid, m_data, m_last} !== '0) begin
        errors++;
        $display("FAIL reset_outs: rd=%b v=%b d=%h l=%b, required all 0",
                 fifo_read, m_valid, m_data, m_last);
      end
    end
    tst_mode = 1'b0;
    m_ready  = 1'b0;
    do_reset();
  endtask

  task automatic test_latency();
    logic [6:0]   rd_v, val_v;
    logic [W-1:0] d2;
    int k;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'hA5);
    k = 0;
    @(negedge clk);
    while (!fifo_read && k < 10) begin
      @(negedge clk);
      k++;
    end
    rd_v[0]  = fifo_read;
    val_v[0] = m_valid;
    d2 = '0;
    for (int c = 1; c < 7; c++) begin
      @(negedge clk);
      rd_v[c]  = fifo_read;
      val_v[c] = m_valid;
      if (c == 2) d2 = m_data;
    end
    checks++;
    if (rd_v !== 7'b1010101) begin
      errors++;
      $display("FAIL lat_reads: pattern %b, required 1010101", rd_v);
    end
    checks++;
    if (val_v[1:0] !== 2'b00 || val_v[2] !== 1'b1 || d2 !== 8'hA5) begin
      errors++;
      $display("FAIL lat_valid: v=%b d2=%h, required v0..2=001 d2=a5",
               val_v[2:0], d2);
    end
    wait_delivered(4, "lat");
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(W'(i));
    repeat (20) tick();
    checks++;
    if (reads != 2) begin
      errors++;
      $display("FAIL bp_reads: %0d reads, required 2", reads);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h01) begin
      errors++;
      $display("FAIL bp_head: v=%b d=%h, required 1/01", m_valid, m_data);
    end
    m_ready = 1'b1;
    wait_delivered(5, "bp");
    repeat (4) tick();
    checks++;
    if (reads != 5 || delivered != 5 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_count: reads=%0d deliv=%0d, required 5/5", reads, delivered);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + W'(i));
    wait_delivered(8, "simul");
    checks++;
    if (reads != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL simul_count: reads=%0d left=%0d, required 8/0", reads, sb.size());
    end
  endtask

  task automatic test_empty();
    do_reset();
    m_ready = 1'b1;
    push(8'h3C);
    repeat (15) tick();
    checks++;
    if (reads != 1 || delivered != 1) begin
      errors++;
      $display("FAIL empty_count: reads=%0d deliv=%0d, required 1/1", reads, delivered);
    end
    checks++;
    if (m_valid !== 1'b0 || fifo_read !== 1'b0) begin
      errors++;
      $display("FAIL empty_idle: v=%b rd=%b, required 0/0", m_valid, fifo_read);
    end
  endtask

  task automatic test_random();
    int k;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push(W'($urandom));
      tick();
    end
    m_ready = 1'b1;
    k = 0;
    while ((sb.size() != 0 || m_valid) && k < 300) begin
      tick();
      k++;
    end
    checks++;
    if (delivered != pushed || sb.size() != 0) begin
      errors++;
      $display("FAIL rand_count: deliv=%0d, required %0d", delivered, pushed);
    end
  endtask

`ifdef FIFO_READER_LAST_EN
  task automatic test_last();
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(W'($urandom));
    wait_delivered(8, "last");
    checks++;
    if (last_mask !== 32'h88) begin
      errors++;
      $display("FAIL last_pos: mask %h, required 00000088", last_mask);
    end
    for (int i = 0; i < 6; i++) push(W'($urandom));
    wait_delivered(8 + 2, "last_mid");
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(W'($urandom));
    wait_delivered(4, "last_rst");
    checks++;
    if (last_mask !== 32'h8) begin
      errors++;
      $display("FAIL last_after_rst: mask %h, required 00000008", last_mask);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_simultaneous();
    test_empty();
    test_random();
`ifdef FIFO_READER_LAST_EN
    test_last();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
